if_fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register and feeds it.
- Owns the program counter and talks to instruction memory over a req/ack handshake.
- Holds fetched instructions in a 2-entry output/skid buffer, so hazard-unit stalls never drop a memory response.
- Applies branch/jump redirects and drives flush to IF/ID so the wrong-path instruction is squashed.

---
 rtl/if_pkg.sv | 21 ++
 rtl/if_fetch_buffer.sv | 65 ++++++
 rtl/if_fetch_unit.sv | 95 +++++++++
 tb/tb_if_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned PC_W   = 10;
  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  // Legacy-compatible state encoding.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FETCH   = 2'd0;
  localparam fetch_state_t DISCARD = 2'd1;
  localparam fetch_state_t FULL    = 2'd2;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              valid;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_buffer.sv
// Two-entry output/skid buffer between instruction memory and IF/ID.
// The out slot drives IF/ID; the skid slot catches a response that
// arrives while IF/ID is stalled on a valid instruction.
module if_fetch_buffer
  import if_pkg::*;
#(
  parameter logic [INST_W-1:0] NopInst = NOP_INST
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clear_i,
  input  logic      consume_i,
  input  logic      load_i,
  input  if_entry_t new_i,
  output if_entry_t out_o,
  output logic      skid_valid_o
);

  if_entry_t out_q, out_d;
  if_entry_t skid_q, skid_d;
  if_entry_t bubble;

  // A bubble keeps the last pc so IF/ID sees a stable PC input.
  assign bubble = '{inst: NopInst, pc: out_q.pc, valid: 1'b0};

  // Next-state selection for both slots.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (clear_i) begin
      out_d        = bubble;
      skid_d.valid = 1'b0;
    end else if (consume_i) begin
      if (skid_q.valid) begin
        out_d = skid_q;
        if (load_i) begin
          skid_d = new_i;
        end else begin
          skid_d.valid = 1'b0;
        end
      end else begin
        out_d = load_i ? new_i : bubble;
      end
    end else if (!out_q.valid) begin
      if (load_i) out_d = new_i;
    end else if (load_i) begin
      skid_d = new_i;
    end
  end

  // Slot registers with asynchronous reset to an empty buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '{inst: NopInst, pc: '0, valid: 1'b0};
      skid_q <= '{inst: NopInst, pc: '0, valid: 1'b0};
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  assign out_o        = out_q;
  assign skid_valid_o = skid_q.valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake,
// buffers responses across stalls and squashes wrong-path fetches.
module if_fetch_unit #(
  parameter logic [if_pkg::PC_W-1:0]   RESET_PC = '0,
  parameter logic [if_pkg::INST_W-1:0] NOP_INST = if_pkg::NOP_INST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      branch_taken_i,
  input  logic [if_pkg::PC_W-1:0]   branch_target_i,
  input  logic                      jump_i,
  input  logic [if_pkg::PC_W-1:0]   jump_target_i,
  output logic                      imem_req_o,
  output logic [if_pkg::PC_W-1:0]   imem_addr_o,
  input  logic                      imem_ack_i,
  input  logic [if_pkg::INST_W-1:0] imem_rdata_i,
  output logic [if_pkg::INST_W-1:0] instruction_o,
  output logic [if_pkg::PC_W-1:0]   pc_out_o,
  output logic                      valid_out_o,
  output logic                      flush_o
);
  import if_pkg::*;

  localparam logic [PC_W-1:0] AlignMask = ~(PC_W'(3));

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, redirect_tgt;
  logic            incoming, redirect;
  if_entry_t       new_entry, out_entry;
  logic            skid_valid;

  assign redirect     = branch_taken_i | jump_i;
  assign redirect_tgt = (jump_i ? jump_target_i : branch_target_i) & AlignMask;
  assign incoming     = (state_q == FETCH) & imem_ack_i;
  assign pc_inc       = pc_q + PC_W'(4);
  assign new_entry    = '{inst: imem_rdata_i, pc: pc_inc, valid: 1'b1};

  assign imem_req_o  = (state_q == FETCH);
  assign imem_addr_o = pc_q;
  assign flush_o     = redirect;

  // PC and FSM next state; a redirect overrides stall and any response.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      pc_d = redirect_tgt;
      // An outstanding request must have its late ack swallowed.
      state_d = ((state_q != FULL) && !imem_ack_i) ? DISCARD : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (incoming) pc_d = pc_inc;
          if (stall_i && out_entry.valid && incoming) state_d = FULL;
        end
        DISCARD: if (imem_ack_i) state_d = FETCH;
        FULL:    if (!stall_i) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_fetch_buffer #(
    .NopInst(NOP_INST)
  ) u_buffer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (redirect),
    .consume_i   (!stall_i),
    .load_i      (incoming & !redirect),
    .new_i       (new_entry),
    .out_o       (out_entry),
    .skid_valid_o(skid_valid)
  );

  assign instruction_o = out_entry.inst;
  assign pc_out_o      = out_entry.pc;
  assign valid_out_o   = out_entry.valid;

  logic unused_skid_valid;
  assign unused_skid_valid = skid_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-based fetch model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken, jump;
  logic [9:0]  branch_target, jump_target;
  logic        imem_req, imem_ack, valid_out, flush;
  logic [9:0]  imem_addr, pc_out;
  logic [31:0] imem_rdata, instruction;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .jump_i         (jump),
    .jump_target_i  (jump_target),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_ack_i     (imem_ack),
    .imem_rdata_i   (imem_rdata),
    .instruction_o  (instruction),
    .pc_out_o       (pc_out),
    .valid_out_o    (valid_out),
    .flush_o        (flush)
  );

  // Instruction word stored at each address.
  function automatic logic [31:0] inst_of(input logic [9:0] a);
    return {a, 6'h2A, ~a, 6'h15};
  endfunction

  // Memory: one ack per request, after mem_lat_q wait cycles.
  int         lat_min = 0, lat_max = 0;
  logic       mem_pend_q;
  int         mem_cnt_q, mem_lat_q;
  logic [9:0] mem_addr_q;

  assign imem_ack   = (mem_pend_q || imem_req) && (mem_cnt_q == mem_lat_q);
  assign imem_rdata = inst_of(mem_pend_q ? mem_addr_q : imem_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_pend_q <= 1'b0;
      mem_cnt_q  <= 0;
      mem_lat_q  <= lat_min;
      mem_addr_q <= '0;
    end else if (imem_ack) begin
      mem_pend_q <= 1'b0;
      mem_cnt_q  <= 0;
      mem_lat_q  <= int'($urandom_range(lat_max, lat_min));
    end else if (mem_pend_q || imem_req) begin
      if (!mem_pend_q) mem_addr_q <= imem_addr;
      mem_pend_q <= 1'b1;
      mem_cnt_q  <= mem_cnt_q + 1;
    end
  end

  // Reference model: delivered-instruction queue, fetch pc, discard flag.
  typedef struct packed {
    logic [31:0] inst;
    logic [9:0]  pc;
  } ref_t;

  ref_t       m_q[$];
  logic [9:0] m_pc;
  logic       m_discard;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc      = 10'h000;
    m_discard = 1'b0;
  endtask

  // One cycle: drive inputs, compare outputs, advance model at the edge.
  task automatic step(input logic st, input logic br, input logic [9:0] bt,
                      input logic jp, input logic [9:0] jt);
    logic e_req, a;
    stall         = st;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    #1;
    e_req = !m_discard && (m_q.size() < 2);
    check_eq("req", 32'(imem_req), 32'(e_req));
    if (e_req) check_eq("addr", 32'(imem_addr), 32'(m_pc));
    check_eq("flush", 32'(flush), 32'(br | jp));
    check_eq("valid", 32'(valid_out), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check_eq("inst", instruction, m_q[0].inst);
      check_eq("pc_out", 32'(pc_out), 32'(m_q[0].pc));
    end else begin
      check_eq("bubble", instruction, 32'h0);
    end
    a = imem_ack;
    @(posedge clk);
    if (br || jp) begin
      m_q.delete();
      m_pc      = (jp ? jt : bt) & 10'h3FC;
      m_discard = (e_req || m_discard) && !a;
    end else if (m_discard) begin
      if (a) m_discard = 1'b0;
    end else begin
      if (!st && m_q.size() > 0) void'(m_q.pop_front());
      if (e_req && a) begin
        m_q.push_back('{inst: inst_of(m_pc), pc: m_pc + 10'd4});
        m_pc = m_pc + 10'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'h0, 1'b0, 10'h0);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    model_reset();
    #1;
    check_eq("rst_valid", 32'(valid_out), 32'h0);
    check_eq("rst_inst", instruction, 32'h0);
    check_eq("rst_pc_out", 32'(pc_out), 32'h0);
    check_eq("rst_addr", 32'(imem_addr), 32'h0);
    check_eq("rst_req", 32'(imem_req), 32'h1);
    check_eq("rst_flush", 32'(flush), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 0-wait streaming.
    idle(12);

    // Stall for 4 cycles mid-stream, then drain.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10'h0, 1'b0, 10'h0);
    idle(6);

    // Slow memory; a branch lands while a request is outstanding.
    lat_min = 2; lat_max = 2;
    idle(8);
    step(1'b0, 1'b1, 10'h040, 1'b0, 10'h0);
    idle(10);

    // Jump and branch together under stall: jump wins, buffer cleared.
    lat_min = 0; lat_max = 0;
    idle(4);
    step(1'b1, 1'b0, 10'h0, 1'b0, 10'h0);
    step(1'b1, 1'b1, 10'h100, 1'b1, 10'h203);
    idle(6);

    // PC wrap: fetch from 0x3FC and continue at 0x000.
    step(1'b0, 1'b0, 10'h0, 1'b1, 10'h3F4);
    idle(8);

    // Random traffic.
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0),
           10'($urandom_range(0, 1023)), 1'($urandom_range(0, 24) == 0),
           10'($urandom_range(0, 1023)));
    end

    // Asynchronous reset while a request is waiting.
    lat_min = 3; lat_max = 3;
    idle(6);
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(valid_out), 32'h0);
    check_eq("arst_inst", instruction, 32'h0);
    check_eq("arst_pc_out", 32'(pc_out), 32'h0);
    check_eq("arst_addr", 32'(imem_addr), 32'h0);
    check_eq("arst_req", 32'(imem_req), 32'h1);
    lat_min = 0; lat_max = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
